// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Program counter / fetch sequencer with branch-target LUT
//                interface, Start/Done handshake and retired-instruction count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
  parameter int PC_W     = 10,
  parameter int CNT_W    = 16,
  parameter int START_PC = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             AbsJump,
  input  logic [PC_W-1:0]  LutIdx,
  output logic [PC_W-1:0]  LutAddr,
  input  logic [PC_W-1:0]  LutTarget,
  output logic [PC_W-1:0]  PC,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [PC_W-1:0]  c_start_pc = START_PC[PC_W-1:0];
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [PC_W-1:0]  c_pc_one   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_busy;
  logic             r_done;

  assign LutAddr    = LutIdx;
  assign PC         = r_pc;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign InstrCount = r_cnt;

  // Counter sticks at all-ones rather than wrapping.
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + c_cnt_one);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = c_start_pc;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (Stall) begin
          w_state_nxt = S_RUN;
        end else if (Halt) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = w_cnt_inc;
        end else if (BranchEn && AbsJump) begin
          w_pc_nxt    = LutTarget;
          w_cnt_nxt   = w_cnt_inc;
        end else if (BranchEn) begin
          // Signed offset: unsigned add of the two's-complement value wraps correctly.
          w_pc_nxt    = r_pc + LutTarget;
          w_cnt_nxt   = w_cnt_inc;
        end else begin
          w_pc_nxt    = r_pc + c_pc_one;
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = c_start_pc;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_pc    <= c_start_pc;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
//  Module      : tb_pc_fetch_ctrl
//  Description : Directed-vector bench for pc_fetch_ctrl with a queue-based
//                scoreboard and a decoupled monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Stall;
  logic        Halt;
  logic        BranchEn;
  logic        AbsJump;
  logic [9:0]  LutIdx;
  logic [9:0]  LutAddr;
  logic [9:0]  LutTarget;
  logic [9:0]  PC;
  logic        Busy;
  logic        Done;
  logic [15:0] InstrCount;

  typedef struct {
    logic [9:0]  pc;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    logic [9:0]  la;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  pc_fetch_ctrl #(.PC_W(10), .CNT_W(16), .START_PC(0)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Stall      (Stall),
    .Halt       (Halt),
    .BranchEn   (BranchEn),
    .AbsJump    (AbsJump),
    .LutIdx     (LutIdx),
    .LutAddr    (LutAddr),
    .LutTarget  (LutTarget),
    .PC         (PC),
    .Busy       (Busy),
    .Done       (Done),
    .InstrCount (InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, id, act, expv);
    end
  endtask

  // Monitor: registered outputs are sampled just after each rising edge,
  // while the inputs of the preceding cycle are still applied.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",      e.id, 32'(PC),         32'(e.pc));
        chk("busy",    e.id, 32'(Busy),       32'(e.busy));
        chk("done",    e.id, 32'(Done),       32'(e.done));
        chk("count",   e.id, 32'(InstrCount), 32'(e.cnt));
        chk("lutaddr", e.id, 32'(LutAddr),    32'(e.la));
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic sl, input logic hl,
                      input logic br, input logic ab, input logic [9:0] idx, input logic [9:0] tgt,
                      input logic [9:0] epc, input logic eb, input logic ed, input logic [15:0] ec);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Start = st; Stall = sl; Halt = hl;
    BranchEn = br; AbsJump = ab; LutIdx = idx; LutTarget = tgt;
    e.pc = epc; e.busy = eb; e.done = ed; e.cnt = ec; e.la = idx; e.id = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Plain sequential fetch in RUN.
  task automatic seq(input logic [9:0] epc, input logic [15:0] ec);
    step(1, 0, 0, 0, 0, 0, 10'(ec), 10'h000, epc, 1, 0, ec);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0; Halt = 1'b0;
    BranchEn = 1'b0; AbsJump = 1'b0; LutIdx = '0; LutTarget = '0;

    // Reset held two cycles, then start and free-run
    step(0, 0, 0, 0, 0, 0, 10'h011, 10'h000, 10'h000, 0, 0, 16'd0);
    step(0, 1, 0, 0, 1, 1, 10'h012, 10'h155, 10'h000, 0, 0, 16'd0);
    step(1, 0, 0, 0, 0, 0, 10'h013, 10'h000, 10'h000, 0, 0, 16'd0);
    step(1, 1, 0, 0, 0, 0, 10'h014, 10'h000, 10'h000, 1, 0, 16'd0);
    seq(10'd1, 16'd1);
    seq(10'd2, 16'd2);
    seq(10'd3, 16'd3);
    seq(10'd4, 16'd4);
    seq(10'd5, 16'd5);

    // Relative branch by -1 from PC=5
    step(1, 0, 0, 0, 1, 0, 10'h002, 10'h3FF, 10'd4, 1, 0, 16'd6);
    seq(10'd5, 16'd7);
    seq(10'd6, 16'd8);
    seq(10'd7, 16'd9);
    seq(10'd8, 16'd10);

    // Absolute branch from PC=8, then wrap at the top of the address space
    step(1, 0, 0, 0, 1, 1, 10'h2A5, 10'h003, 10'd3,   1, 0, 16'd11);
    step(1, 0, 0, 0, 1, 1, 10'h001, 10'h3FF, 10'h3FF, 1, 0, 16'd12);
    seq(10'd0, 16'd13);
    step(1, 0, 0, 0, 1, 1, 10'h004, 10'h3FE, 10'h3FE, 1, 0, 16'd14);
    // 0x3FE + 5 wraps to 3
    step(1, 0, 0, 0, 1, 0, 10'h005, 10'h005, 10'd3,   1, 0, 16'd15);
    // Self-loop: zero offset still retires
    step(1, 0, 0, 0, 1, 0, 10'h006, 10'h000, 10'd3,   1, 0, 16'd16);

    // Stall with a pending branch, and stall masking halt
    step(1, 0, 1, 0, 1, 1, 10'h007, 10'h040, 10'd3, 1, 0, 16'd16);
    step(1, 0, 1, 0, 1, 1, 10'h007, 10'h040, 10'd3, 1, 0, 16'd16);
    step(1, 0, 1, 0, 1, 1, 10'h007, 10'h040, 10'd3, 1, 0, 16'd16);
    step(1, 0, 1, 1, 0, 0, 10'h008, 10'h000, 10'd3, 1, 0, 16'd16);
    step(1, 0, 0, 0, 1, 1, 10'h007, 10'h040, 10'h040, 1, 0, 16'd17);

    // Halt together with branch: halt wins, PC holds
    step(1, 0, 0, 1, 1, 1, 10'h009, 10'h100, 10'h040, 0, 1, 16'd18);
    step(1, 0, 0, 0, 0, 0, 10'h00A, 10'h000, 10'h040, 0, 1, 16'd18);
    step(1, 0, 0, 1, 1, 0, 10'h00B, 10'h001, 10'h040, 0, 1, 16'd18);

    // Restart from DONE, 4 instructions, halt, restart
    step(1, 1, 0, 0, 0, 0, 10'h00C, 10'h000, 10'd0, 1, 0, 16'd0);
    seq(10'd1, 16'd1);
    seq(10'd2, 16'd2);
    seq(10'd3, 16'd3);
    seq(10'd4, 16'd4);
    step(1, 0, 0, 1, 0, 0, 10'h00D, 10'h000, 10'd4, 0, 1, 16'd5);
    step(1, 0, 0, 0, 0, 0, 10'h00E, 10'h000, 10'd4, 0, 1, 16'd5);
    step(1, 1, 0, 0, 0, 0, 10'h00F, 10'h000, 10'd0, 1, 0, 16'd0);

    // Start ignored while running; reset mid-RUN with a branch pending at PC=7
    seq(10'd1, 16'd1);
    seq(10'd2, 16'd2);
    seq(10'd3, 16'd3);
    step(1, 1, 0, 0, 0, 0, 10'h010, 10'h000, 10'd4, 1, 0, 16'd4);
    step(1, 1, 0, 0, 0, 0, 10'h010, 10'h000, 10'd5, 1, 0, 16'd5);
    seq(10'd6, 16'd6);
    seq(10'd7, 16'd7);
    step(0, 0, 0, 0, 1, 1, 10'h3C3, 10'h055, 10'd0, 0, 0, 16'd0);
    step(1, 0, 0, 0, 0, 0, 10'h020, 10'h000, 10'd0, 0, 0, 16'd0);
    step(1, 0, 0, 1, 1, 1, 10'h021, 10'h055, 10'd0, 0, 0, 16'd0);
    step(1, 1, 0, 0, 0, 0, 10'h022, 10'h000, 10'd0, 1, 0, 16'd0);
    seq(10'd1, 16'd1);

    begin
      int budget = 50;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge Clk);
        budget--;
      end
      #2;
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
